// File: rtl/sap_ctrl_seq.sv
// SAP-1 control sequencer: T1..T6 ring counter, per-state opcode decode, run/pause/step, sticky halt.
// Optional macro SAP_JUMP_EN enables JMP/JC/JZ decoding; without it those opcodes are NOPs and lp stays 0.
//
// state | meaning
// T1    | fetch: PC onto bus, MAR load
// T2    | fetch: PC increment
// T3    | fetch: RAM onto bus, IR load
// T4    | execute step 1 (address phase / OUT / HLT / jumps)
// T5    | execute step 2 (RAM operand read)
// T6    | execute step 3 (ALU result write-back)
module sap_ctrl_seq #(
   parameter int OPC_W   = 4,
   parameter int NSTATES = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic [OPC_W-1:0] opcode,
   input  logic             carry,
   input  logic             zero,
   output logic [5:0]       t_state,
   output logic             cp,
   output logic             ep,
   output logic             lm,
   output logic             ce,
   output logic             li,
   output logic             ei,
   output logic             la,
   output logic             ea,
   output logic             lb,
   output logic             su,
   output logic             eu,
   output logic             fi,
   output logic             lo,
   output logic             lp,
   output logic             halted
);

   if (NSTATES != 6) begin : g_nstates_check
      $error("sap_ctrl_seq supports only NSTATES = 6");
   end

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } t_state_e;

   localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h0);
   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h1);
   localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h2);
   localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
   localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);
`ifdef SAP_JUMP_EN
   localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h6);
   localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h7);
   localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h8);
`else
   logic unused_flags;
   assign unused_flags = carry ^ zero;
`endif

   t_state_e state, state_next;
   logic     halted_next;
   logic     adv;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= T1;
         halted <= 1'b0;
      end else begin
         state  <= state_next;
         halted <= halted_next;
      end
   end

   assign t_state = state;

   always_comb begin
      state_next  = state;
      halted_next = halted;
      adv         = !halted && (run || step);
      cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0;
      ei = 1'b0; la = 1'b0; ea = 1'b0; lb = 1'b0; su = 1'b0;
      eu = 1'b0; fi = 1'b0; lo = 1'b0; lp = 1'b0;

      if (adv) begin
         case (state)
            T1:      state_next = T2;
            T2:      state_next = T3;
            T3:      state_next = T4;
            T4:      state_next = T5;
            T5:      state_next = T6;
            T6:      state_next = T1;
            default: state_next = T1;
         endcase
         if (state == T4 && opcode == OP_HLT)
            halted_next = 1'b1;
      end

      // The control word is held at zero while in reset or halted so the datapath sees no strobes.
      if (rst && !halted) begin
         case (state)
            T1: begin ep = 1'b1; lm = 1'b1; end
            T2: cp = 1'b1;
            T3: begin ce = 1'b1; li = 1'b1; end
            T4: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                  OP_OUT: begin ea = 1'b1; lo = 1'b1; end
`ifdef SAP_JUMP_EN
                  OP_JMP: begin ei = 1'b1; lp = 1'b1; end
                  OP_JC:  begin ei = carry; lp = carry; end
                  OP_JZ:  begin ei = zero;  lp = zero;  end
`endif
                  default: ;
               endcase
            end
            T5: begin
               case (opcode)
                  OP_LDA: begin ce = 1'b1; la = 1'b1; end
                  OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
                  default: ;
               endcase
            end
            T6: begin
               case (opcode)
                  OP_ADD: begin eu = 1'b1; la = 1'b1; fi = 1'b1; end
                  OP_SUB: begin su = 1'b1; eu = 1'b1; la = 1'b1; fi = 1'b1; end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
